// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: data width, NOP encoding, fetch FSM states,
// and the {pc, instr} payload carried between the skid buffer and IF/ID.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch that completed while ID
// was stalled. Clear wins over load, load wins over unload.
module if_skid_buf
   import riscv_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         unload_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output logic         valid_o,
   output fetch_entry_t entry_o
);

   logic         valid_d, valid_q;
   fetch_entry_t entry_d, entry_q;

   // Next-state for occupancy and payload
   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         entry_d = entry_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end
   end

   // Buffer registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign valid_o = valid_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: req/ack to variable-latency instruction memory,
// IF/ID pipeline register, PC hold back-pressure, stall/flush handling and
// sticky halt at HALT_ADDR.
// Build option: define IF_PERF_CNT_EN to add fetch_cnt_o / bubble_cnt_o.
module if_fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] HALT_ADDR = 32'd248
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   output logic            pc_hold_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            ifid_valid_o,
   output logic [XLEN-1:0] ifid_pc_o,
   output logic [XLEN-1:0] ifid_instr_o,
   output logic            halted_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     fetch_cnt_o,
   output logic [31:0]     bubble_cnt_o
`endif
);

   fetch_state_e    state_d, state_q;
   logic [XLEN-1:0] drop_addr_d, drop_addr_q;
   logic            halted_d, halted_q;
   logic            ifid_valid_d, ifid_valid_q;
   logic [XLEN-1:0] ifid_pc_d, ifid_pc_q;
   logic [XLEN-1:0] ifid_instr_d, ifid_instr_q;

   logic            ifid_free;
   logic            ifid_load;
   fetch_entry_t    load_entry;
   fetch_entry_t    mem_entry;

   logic            skid_load;
   logic            skid_unload;
   logic            skid_clear;
   logic            skid_valid;
   fetch_entry_t    skid_entry;

   // IF/ID can take a new instruction when empty or when ID is consuming
   assign ifid_free = !ifid_valid_q || !stall_i;
   assign mem_entry = '{pc: fetch_pc_i, instr: imem_rdata_i};

   if_skid_buf u_skid (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .entry_i  (mem_entry),
      .valid_o  (skid_valid),
      .entry_o  (skid_entry)
   );

   // Fetch FSM: next state, memory handshake, PC hold and IF/ID load select
   always_comb begin
      state_d     = state_q;
      drop_addr_d = drop_addr_q;
      halted_d    = halted_q;
      imem_req_o  = 1'b0;
      imem_addr_o = fetch_pc_i;
      pc_hold_o   = 1'b1;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;
      ifid_load   = 1'b0;
      load_entry  = mem_entry;

      case (state_q)
         REQ: begin
            imem_req_o = 1'b1;
            if (flush_i) begin
               pc_hold_o  = 1'b0;
               skid_clear = 1'b1;
               // An open request must still be completed, just not used
               if (!imem_ack_i) begin
                  drop_addr_d = fetch_pc_i;
                  state_d     = DROP;
               end
            end else if (imem_ack_i) begin
               pc_hold_o = 1'b0;
               if (ifid_free) begin
                  ifid_load = 1'b1;
               end else begin
                  skid_load = 1'b1;
                  state_d   = HOLD;
               end
            end
         end

         HOLD: begin
            if (flush_i) begin
               pc_hold_o  = 1'b0;
               skid_clear = 1'b1;
               state_d    = REQ;
            end else if (!stall_i && skid_valid) begin
               skid_unload = 1'b1;
               ifid_load   = 1'b1;
               load_entry  = skid_entry;
               state_d     = REQ;
            end
         end

         DROP: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drop_addr_q;
            if (flush_i) begin
               pc_hold_o = 1'b0;
            end
            // The orphaned request ends on its ack; its data is thrown away
            if (imem_ack_i) begin
               state_d = REQ;
            end
         end

         HALT: begin
            // PC stays frozen once halted; only reset leaves this state
            if (flush_i) begin
               skid_clear = 1'b1;
            end
         end

         default: begin
            state_d = REQ;
         end
      endcase

      if (ifid_load && (load_entry.pc == HALT_ADDR)) begin
         state_d  = HALT;
         halted_d = 1'b1;
      end
   end

   // IF/ID next value: flush kills, load replaces, unstalled ID drains
   always_comb begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      if (flush_i) begin
         ifid_valid_d = 1'b0;
      end else if (ifid_load) begin
         ifid_valid_d = 1'b1;
         ifid_pc_d    = load_entry.pc;
         ifid_instr_d = load_entry.instr;
      end else if (!stall_i) begin
         ifid_valid_d = 1'b0;
      end
   end

   // State, halt and IF/ID registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= REQ;
         drop_addr_q  <= '0;
         halted_q     <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         drop_addr_q  <= drop_addr_d;
         halted_q     <= halted_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
      end
   end

   assign ifid_valid_o = ifid_valid_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign ifid_instr_o = ifid_instr_q;
   assign halted_o     = halted_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_d, fetch_cnt_q;
   logic [31:0] bubble_cnt_d, bubble_cnt_q;

   // Free-running (wrapping) fetch and bubble counters
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + (ifid_load ? 32'd1 : 32'd0);
      bubble_cnt_d = bubble_cnt_q + ((!ifid_valid_q && !halted_q) ? 32'd1 : 32'd0);
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: directed per-cycle vectors drive the
// memory/ID side and check the handshake; a negedge monitor pops expected
// IF/ID contents whenever a new instruction is presented.
module tb_if_fetch_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_hold;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        ack;
   logic [31:0] rdata;
   logic        stall;
   logic        flush;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        halted;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   logic [31:0] redirect;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_valid = 1'b0;
   logic prev_stall = 1'b0;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .fetch_pc_i   (pc),
      .pc_hold_o    (pc_hold),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (ack),
      .imem_rdata_i (rdata),
      .stall_i      (stall),
      .flush_i      (flush),
      .ifid_valid_o (ifid_valid),
      .ifid_pc_o    (ifid_pc),
      .ifid_instr_o (ifid_instr),
      .halted_o     (halted)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o  (fetch_cnt),
      .bubble_cnt_o (bubble_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i);
      exp_t e;
      e.pc    = p;
      e.instr = i;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; checks combinational handshake outputs, then the
   // bench's PC register advances unless the DUT asked it to hold
   task automatic step(input logic a, input logic [31:0] d, input logic s, input logic f,
                       input logic e_req, input logic e_hold, input logic [31:0] e_addr,
                       input string nm);
      logic h;
      ack   = a;
      rdata = d;
      stall = s;
      flush = f;
      #1;
      chk({nm, "_req"},  32'(imem_req), 32'(e_req));
      chk({nm, "_hold"}, 32'(pc_hold),  32'(e_hold));
      if (e_req) chk({nm, "_addr"}, imem_addr, e_addr);
      h = pc_hold;
      @(posedge clk);
      #1;
      if (!h) pc = f ? redirect : pc + 32'd4;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      rst   = 1'b1;
      ack   = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      rdata = '0;
      pc    = start_pc;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: a new IF/ID entry is visible when valid and the previous edge
   // either had IF/ID empty or ID not stalled
   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
         prev_stall <= 1'b0;
      end else begin
         if (ifid_valid && (!prev_valid || !prev_stall)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got pc %h instr %h expected nothing", ifid_pc, ifid_instr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_pc", ifid_pc, mon_e.pc);
               chk("sb_instr", ifid_instr, mon_e.instr);
            end
         end
         prev_valid <= ifid_valid;
         prev_stall <= stall;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      redirect = '0;
      do_reset(32'h0);

      // Reset state
      chk("rst_valid",  32'(ifid_valid), 32'd0);
      chk("rst_pc",     ifid_pc,         32'd0);
      chk("rst_instr",  ifid_instr,      32'h0000_0013);
      chk("rst_halted", 32'(halted),     32'd0);

      // Back-to-back 1-cycle-ack fetches
      push(32'h0, 32'h0010_0093);
      push(32'h4, 32'h0020_0113);
      push(32'h8, 32'h0030_0193);
      step(1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "s1_f0");
      step(1'b1, 32'h0020_0113, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, "s1_f4");
      step(1'b1, 32'h0030_0193, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, "s1_f8");
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'hc, "s1_wait");

      // Latency-3 memory at 0x10
      do_reset(32'h10);
      push(32'h10, 32'h0040_0213);
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h10, "s2_w1");
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h10, "s2_w2");
      chk("s2_notyet", 32'(ifid_valid), 32'd0);
      step(1'b1, 32'h0040_0213, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, "s2_ack");
      chk("s2_loaded", 32'(ifid_valid), 32'd1);
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h14, "s2_next");

      // 4-cycle stall with ack arriving mid-stall
      do_reset(32'h40);
      push(32'h40, 32'h0050_0293);
      push(32'h44, 32'h0060_0313);
      push(32'h48, 32'h0070_0393);
      step(1'b1, 32'h0050_0293, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, "s3_f40");
      step(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h44, "s3_st1");
      step(1'b1, 32'h0060_0313, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44, "s3_st2");
      chk("s3_held_pc", ifid_pc, 32'h40);
      step(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  "s3_st3");
      step(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  "s3_st4");
      chk("s3_held_pc2",    ifid_pc,    32'h40);
      chk("s3_held_instr",  ifid_instr, 32'h0050_0293);
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  "s3_unload");
      chk("s3_skid_pc", ifid_pc, 32'h44);
      step(1'b1, 32'h0070_0393, 1'b0, 1'b0, 1'b1, 1'b0, 32'h48, "s3_f48");
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h4c, "s3_drain");

      // Flush while 0x20 is outstanding; ack two cycles later
      do_reset(32'h20);
      redirect = 32'h80;
      step(1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h20, "s4_flush");
      chk("s4_v0", 32'(ifid_valid), 32'd0);
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h20, "s4_drop1");
      chk("s4_v1", 32'(ifid_valid), 32'd0);
      step(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, "s4_dropack");
      chk("s4_v2", 32'(ifid_valid), 32'd0);
      push(32'h80, 32'h0080_0413);
      step(1'b1, 32'h0080_0413, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, "s4_f80");
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h84, "s4_drain");

      // Run into the halt address
      do_reset(32'hf0);
      push(32'hf0, 32'h0090_0493);
      push(32'hf4, 32'h00a0_0513);
      push(32'hf8, 32'h00b0_0593);
      step(1'b1, 32'h0090_0493, 1'b0, 1'b0, 1'b1, 1'b0, 32'hf0, "s5_ff0");
      step(1'b1, 32'h00a0_0513, 1'b0, 1'b0, 1'b1, 1'b0, 32'hf4, "s5_ff4");
      chk("s5_not_halted", 32'(halted), 32'd0);
      step(1'b1, 32'h00b0_0593, 1'b0, 1'b0, 1'b1, 1'b0, 32'hf8, "s5_ff8");
      chk("s5_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "s5_idle");
      end
      chk("s5_still_halted", 32'(halted), 32'd1);
      do_reset(32'h0);
      chk("s5_rst_clear", 32'(halted), 32'd0);

      // Flush, ack and stall together with IF/ID valid
      do_reset(32'h100);
      redirect = 32'h200;
      push(32'h100, 32'h00c0_0613);
      step(1'b1, 32'h00c0_0613, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, "s6_f100");
      step(1'b1, 32'hbad0_0bad, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104, "s6_all");
      chk("s6_killed", 32'(ifid_valid), 32'd0);
      push(32'h200, 32'h00d0_0693);
      step(1'b1, 32'h00d0_0693, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, "s6_f200");
      step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h204, "s6_drain");

      repeat (2) @(negedge clk);
      #1;
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
